// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback and drives all datapath controls.
module multicycle_control (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       memReady,
    output logic       pcWrite,
    output logic       pcWriteCond,
    output logic       iorD,
    output logic       memRead,
    output logic       memWrite,
    output logic       irWrite,
    output logic       regDst,
    output logic       memToReg,
    output logic       regWrite,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] aluOp,
    output logic       aluFuncSel,
    output logic       zeroExt,
    output logic [1:0] pcSource,
    output logic       illegalOp,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_IEXEC  = 4'd9,
        S_IWB    = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;

    state_t state_q, state_d;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    // Reset forces every output low combinationally, including the debug state.
    assign state = rst ? 4'd0 : 4'(state_q);

    always_comb begin
        state_d     = S_FETCH;
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        iorD        = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        irWrite     = 1'b0;
        regDst      = 1'b0;
        memToReg    = 1'b0;
        regWrite    = 1'b0;
        aluSrcA     = 1'b0;
        aluSrcB     = 2'b00;
        aluOp       = 2'b00;
        aluFuncSel  = 1'b0;
        zeroExt     = 1'b0;
        pcSource    = 2'b00;
        illegalOp   = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    memRead = 1'b1;
                    aluSrcB = 2'b01;
                    irWrite = memReady;
                    pcWrite = memReady;
                    state_d = memReady ? S_DECODE : S_FETCH;
                end
                S_DECODE: begin
                    aluSrcB = 2'b11;
                    case (opcode)
                        OP_LW, OP_SW:             state_d = S_MEMADR;
                        OP_R:                     state_d = S_EXEC;
                        OP_BEQ:                   state_d = S_BRANCH;
                        OP_J:                     state_d = S_JUMP;
                        OP_ADDI, OP_ANDI, OP_ORI: state_d = S_IEXEC;
                        default: begin
                            state_d   = S_FETCH;
                            illegalOp = 1'b1;
                        end
                    endcase
                end
                S_MEMADR: begin
                    aluSrcA = 1'b1;
                    aluSrcB = 2'b10;
                    if (opcode == OP_LW)      state_d = S_MEMRD;
                    else if (opcode == OP_SW) state_d = S_MEMWR;
                    else                      state_d = S_FETCH;
                end
                S_MEMRD: begin
                    iorD    = 1'b1;
                    memRead = 1'b1;
                    state_d = memReady ? S_MEMWB : S_MEMRD;
                end
                S_MEMWB: begin
                    memToReg = 1'b1;
                    regWrite = 1'b1;
                end
                S_MEMWR: begin
                    iorD     = 1'b1;
                    memWrite = 1'b1;
                    state_d  = memReady ? S_FETCH : S_MEMWR;
                end
                S_EXEC: begin
                    aluSrcA = 1'b1;
                    aluOp   = 2'b10;
                    state_d = S_ALUWB;
                end
                S_ALUWB: begin
                    regDst   = 1'b1;
                    regWrite = 1'b1;
                end
                S_BRANCH: begin
                    aluSrcA     = 1'b1;
                    aluOp       = 2'b01;
                    pcSource    = 2'b01;
                    pcWriteCond = 1'b1;
                end
                S_IEXEC: begin
                    aluSrcA    = 1'b1;
                    aluSrcB    = 2'b10;
                    aluOp      = 2'b11;
                    aluFuncSel = 1'b1;
                    zeroExt    = (opcode == OP_ANDI) || (opcode == OP_ORI);
                    state_d    = S_IWB;
                end
                S_IWB: begin
                    regWrite = 1'b1;
                end
                S_JUMP: begin
                    pcSource = 2'b10;
                    pcWrite  = 1'b1;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed-vector bench for multicycle_control.
// Each step drives inputs after the falling edge and checks state plus all controls.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       memReady;
    logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
    logic       regDst, memToReg, regWrite, aluSrcA, aluFuncSel, zeroExt;
    logic       illegalOp;
    logic [1:0] aluSrcB, aluOp, pcSource;
    logic [3:0] state;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .memReady(memReady),
        .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD),
        .memRead(memRead), .memWrite(memWrite), .irWrite(irWrite),
        .regDst(regDst), .memToReg(memToReg), .regWrite(regWrite),
        .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
        .aluFuncSel(aluFuncSel), .zeroExt(zeroExt), .pcSource(pcSource),
        .illegalOp(illegalOp), .state(state)
    );

    // Control vector bit positions, MSB to LSB.
    localparam logic [18:0] B_PW   = 19'd1 << 18;
    localparam logic [18:0] B_PWC  = 19'd1 << 17;
    localparam logic [18:0] B_IORD = 19'd1 << 16;
    localparam logic [18:0] B_MR   = 19'd1 << 15;
    localparam logic [18:0] B_MW   = 19'd1 << 14;
    localparam logic [18:0] B_IRW  = 19'd1 << 13;
    localparam logic [18:0] B_RDST = 19'd1 << 12;
    localparam logic [18:0] B_M2R  = 19'd1 << 11;
    localparam logic [18:0] B_RW   = 19'd1 << 10;
    localparam logic [18:0] B_SA   = 19'd1 << 9;
    localparam logic [18:0] SB1    = 19'd1 << 7;
    localparam logic [18:0] SB2    = 19'd2 << 7;
    localparam logic [18:0] SB3    = 19'd3 << 7;
    localparam logic [18:0] OP1    = 19'd1 << 5;
    localparam logic [18:0] OP2    = 19'd2 << 5;
    localparam logic [18:0] OP3    = 19'd3 << 5;
    localparam logic [18:0] B_FS   = 19'd1 << 4;
    localparam logic [18:0] B_ZE   = 19'd1 << 3;
    localparam logic [18:0] PS1    = 19'd1 << 1;
    localparam logic [18:0] PS2    = 19'd2 << 1;
    localparam logic [18:0] B_ILL  = 19'd1;

    localparam logic [18:0] C_FWAIT  = B_MR | SB1;
    localparam logic [18:0] C_FRDY   = B_MR | SB1 | B_IRW | B_PW;
    localparam logic [18:0] C_DEC    = SB3;
    localparam logic [18:0] C_DECILL = SB3 | B_ILL;
    localparam logic [18:0] C_MADR   = B_SA | SB2;
    localparam logic [18:0] C_MRD    = B_IORD | B_MR;
    localparam logic [18:0] C_MWB    = B_M2R | B_RW;
    localparam logic [18:0] C_MWR    = B_IORD | B_MW;
    localparam logic [18:0] C_EXEC   = B_SA | OP2;
    localparam logic [18:0] C_ALUWB  = B_RDST | B_RW;
    localparam logic [18:0] C_BR     = B_SA | OP1 | PS1 | B_PWC;
    localparam logic [18:0] C_IEX    = B_SA | SB2 | OP3 | B_FS;
    localparam logic [18:0] C_IWB    = B_RW;
    localparam logic [18:0] C_JMP    = PS2 | B_PW;

    localparam logic [5:0] O_R    = 6'b000000;
    localparam logic [5:0] O_LW   = 6'b100011;
    localparam logic [5:0] O_SW   = 6'b101011;
    localparam logic [5:0] O_BEQ  = 6'b000100;
    localparam logic [5:0] O_J    = 6'b000010;
    localparam logic [5:0] O_ADDI = 6'b001000;
    localparam logic [5:0] O_ORI  = 6'b001101;
    localparam logic [5:0] O_BAD  = 6'b111111;

    logic [18:0] ctl;
    assign ctl = {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite,
                  regDst, memToReg, regWrite, aluSrcA, aluSrcB, aluOp,
                  aluFuncSel, zeroExt, pcSource, illegalOp};

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge; leaves at the next falling edge.
    task automatic step(input string tag, input logic r, input logic [5:0] opc,
                        input logic mr, input logic [3:0] exp_st,
                        input logic [18:0] exp_ctl);
        rst      = r;
        opcode   = opc;
        memReady = mr;
        #1;
        check({tag, ".state"}, 32'(state), 32'(exp_st));
        check({tag, ".ctl"}, 32'(ctl), 32'(exp_ctl));
        @(negedge clk);
    endtask

    initial begin
        rst      = 1'b1;
        opcode   = 6'd0;
        memReady = 1'b0;
        @(negedge clk);
        step("rst0", 1, O_R, 1, 4'd0, 19'd0);
        step("rst1", 1, O_LW, 1, 4'd0, 19'd0);

        step("r.f",    0, O_R, 1, 4'd0, C_FRDY);
        step("r.dec",  0, O_R, 1, 4'd1, C_DEC);
        step("r.exec", 0, O_R, 1, 4'd6, C_EXEC);
        step("r.wb",   0, O_R, 1, 4'd7, C_ALUWB);

        step("lw.f",   0, O_LW, 1, 4'd0, C_FRDY);
        step("lw.dec", 0, O_LW, 1, 4'd1, C_DEC);
        step("lw.adr", 0, O_LW, 1, 4'd2, C_MADR);
        step("lw.rd0", 0, O_LW, 0, 4'd3, C_MRD);
        step("lw.rd1", 0, O_R,  0, 4'd3, C_MRD);
        step("lw.rd2", 0, O_R,  1, 4'd3, C_MRD);
        step("lw.wb",  0, O_R,  1, 4'd4, C_MWB);

        step("fw.0",   0, O_ORI, 0, 4'd0, C_FWAIT);
        step("fw.1",   0, O_ORI, 0, 4'd0, C_FWAIT);
        step("fw.2",   0, O_ORI, 0, 4'd0, C_FWAIT);
        step("fw.3",   0, O_ORI, 1, 4'd0, C_FRDY);
        step("ori.dec", 0, O_ORI, 0, 4'd1, C_DEC);
        step("ori.ex",  0, O_ORI, 0, 4'd9, C_IEX | B_ZE);
        step("ori.wb",  0, O_ORI, 0, 4'd10, C_IWB);

        step("addi.f",   0, O_ADDI, 1, 4'd0, C_FRDY);
        step("addi.dec", 0, O_ADDI, 1, 4'd1, C_DEC);
        step("addi.ex",  0, O_ADDI, 1, 4'd9, C_IEX);
        step("addi.wb",  0, O_ADDI, 1, 4'd10, C_IWB);

        step("beq.f",   0, O_BEQ, 1, 4'd0, C_FRDY);
        step("beq.dec", 0, O_BEQ, 1, 4'd1, C_DEC);
        step("beq.br",  0, O_BEQ, 1, 4'd8, C_BR);

        step("j.f",   0, O_J, 1, 4'd0, C_FRDY);
        step("j.dec", 0, O_J, 1, 4'd1, C_DEC);
        step("j.jmp", 0, O_J, 1, 4'd11, C_JMP);

        step("ill.f",   0, O_BAD, 1, 4'd0, C_FRDY);
        step("ill.dec", 0, O_BAD, 1, 4'd1, C_DECILL);
        step("ill.f2",  0, O_BAD, 0, 4'd0, C_FWAIT);

        step("sw.f",   0, O_SW, 1, 4'd0, C_FRDY);
        step("sw.dec", 0, O_SW, 1, 4'd1, C_DEC);
        step("sw.adr", 0, O_SW, 1, 4'd2, C_MADR);
        step("sw.wr0", 0, O_SW, 0, 4'd5, C_MWR);
        step("sw.wr1", 0, O_SW, 0, 4'd5, C_MWR);
        step("sw.rst", 1, O_SW, 0, 4'd0, 19'd0);
        step("sw.a0",  0, O_SW, 0, 4'd0, C_FWAIT);
        step("sw.a1",  0, O_SW, 0, 4'd0, C_FWAIT);
        step("sw.a2",  0, O_SW, 1, 4'd0, C_FRDY);
        step("sw.a3",  0, O_R,  1, 4'd1, C_DEC);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multicycle MIPS datapath. It sits directly upstream of the ALU control decoder and drives its 2-bit `aluOp`. It sequences each instruction through fetch, decode, execute, memory and writeback states, and issues all datapath enables and mux selects. It waits on a memory-ready handshake for every memory access.

## Interface
Parameters:
- none (opcodes and state encodings are fixed below)

Ports:
- `clk` in 1: single system clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `opcode` in 6: `IR[31:26]`, stable from the cycle after FETCH completes.
- `memReady` in 1: memory has completed the current read or write this cycle.
- `pcWrite` out 1: unconditional PC load.
- `pcWriteCond` out 1: PC load qualified by ALU zero (beq), gated in the datapath.
- `iorD` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `memRead` out 1: memory read strobe.
- `memWrite` out 1: memory write strobe.
- `irWrite` out 1: instruction register load.
- `regDst` out 1: write-register select; 0 = rt, 1 = rd.
- `memToReg` out 1: write-data select; 0 = ALUOut, 1 = MDR.
- `regWrite` out 1: register file write enable.
- `aluSrcA` out 1: ALU A input; 0 = PC, 1 = register A.
- `aluSrcB` out 2: ALU B input; 00 = B, 01 = const 4, 10 = immediate, 11 = immediate<<2.
- `aluOp` out 2: drives the ALU control decoder; 00 = add, 01 = sub, 10 = R-type funct, 11 = I-type.
- `aluFuncSel` out 1: 1 = datapath steers `opcode` (not funct) onto the ALU control function input.
- `zeroExt` out 1: 1 = zero-extend the immediate (ori/andi); 0 = sign-extend.
- `pcSource` out 2: PC next select; 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `illegalOp` out 1: one-cycle pulse when an unsupported opcode is decoded.
- `state` out 4: current state encoding, for debug.

## Operation
- Supported opcodes:
  - R-type: 000000
  - lw: 100011
  - sw: 101011
  - beq: 000100
  - j: 000010
  - addi: 001000
  - andi: 001100
  - ori: 001101
- Outputs are a Moore decode of `state`, except the signals noted as gated by `memReady`. Any output not listed for a state is 0.
- State actions and transitions:
  - FETCH (0): `memRead`=1, `aluSrcB`=01. `irWrite`=`pcWrite`=`memReady`. Go to DECODE when `memReady`=1, else stay.
  - DECODE (1): `aluSrcB`=11 (branch target precompute). Next state by opcode:
    - lw/sw → MEMADR
    - R → EXEC
    - beq → BRANCH
    - j → JUMP
    - addi/andi/ori → IEXEC
    - any other opcode → FETCH, with `illegalOp`=1 this cycle.
  - MEMADR (2): `aluSrcA`=1, `aluSrcB`=10. Go to MEMRD for lw, MEMWR for sw.
  - MEMRD (3): `iorD`=1, `memRead`=1. Go to MEMWB on `memReady`, else stay.
  - MEMWB (4): `memToReg`=1, `regWrite`=1. Go to FETCH.
  - MEMWR (5): `iorD`=1, `memWrite`=1. Go to FETCH on `memReady`, else stay.
  - EXEC (6): `aluSrcA`=1, `aluOp`=10. Go to ALUWB.
  - ALUWB (7): `regDst`=1, `regWrite`=1. Go to FETCH.
  - BRANCH (8): `aluSrcA`=1, `aluOp`=01, `pcSource`=01, `pcWriteCond`=1. Go to FETCH.
  - IEXEC (9): `aluSrcA`=1, `aluSrcB`=10, `aluOp`=11, `aluFuncSel`=1, `zeroExt`=(opcode is andi or ori). Go to IWB.
  - IWB (10): `regWrite`=1, `regDst`=0, `memToReg`=0. Go to FETCH.
  - JUMP (11): `pcSource`=10, `pcWrite`=1. Go to FETCH.
- Encodings 12–15 are unreachable. If entered, they decode as all-zero outputs and go to FETCH on the next edge.

## Timing
- Reset:
  - While `rst`=1, every output is 0, `state` reads 0, and `state` loads FETCH at the edge.
  - The first FETCH outputs appear in the first cycle with `rst`=0.
  - Reset asserted in any state, including a mid-wait MEMWR, aborts the instruction at the next edge. No further write strobes are issued.
- Latency with `memReady` held high:
  - lw: 5 cycles
  - sw, R-type, I-type: 4 cycles
  - beq, j: 3 cycles
- Each low cycle of `memReady` in FETCH, MEMRD or MEMWR adds one cycle. Strobes stay asserted and the address select stays stable while waiting.
- `irWrite` and `pcWrite` in FETCH pulse for exactly one cycle: the cycle in which `memReady`=1.
- `opcode` is sampled only in DECODE, MEMADR and IEXEC. Changes to it in other states have no effect.

## Test plan
- R-type with `memReady`=1:
  - Required state sequence: 0,1,6,7,0.
  - `aluOp`=10 in state 6; `regWrite`=1 and `regDst`=1 only in state 7.
- lw with `memReady` low for 2 cycles in MEMRD:
  - Required state sequence: 0,1,2,3,3,3,4,0.
  - `iorD`=1 and `memRead`=1 held through all three MEMRD cycles.
  - `memToReg`=1 and `regWrite`=1 in state 4.
- FETCH with `memReady`=0 for 3 cycles, then 1:
  - `irWrite` and `pcWrite` are 0 for 3 cycles, then 1 for exactly one cycle; `state` then moves to DECODE.
- ori (001101):
  - Required state sequence: 0,1,9,10,0.
  - State 9: `aluOp`=11, `aluFuncSel`=1, `zeroExt`=1.
  - addi (001000): identical sequence, but `zeroExt`=0.
- beq, then j, then opcode 111111:
  - beq: 0,1,8,0 with `pcWriteCond`=1 and `pcSource`=01 in state 8.
  - j: 0,1,11,0 with `pcWrite`=1 and `pcSource`=10 in state 11.
  - 111111: `illegalOp` pulses one cycle in DECODE, then FETCH.
- sw waiting in MEMWR, `rst` asserted for one cycle:
  - All outputs 0 during the `rst` cycle.
  - `state`=0 after the edge.
  - No `memWrite` after `rst` falls until a new sw is decoded.
